wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  MEM-stage result valid
- ready_out  out  1  wb_stage accepts MEM result
- PC_MEM  in  32  PC of the instruction
- IR_MEM  in  32  instruction word
- addr_MEM  in  32  effective load/store address or jump target
- imem_axi_rresp_MEM  in  2  fetch response; non-zero means fault
- illegal_inst_MEM, maligned_inst_addr_MEM, maligned_load_addr_MEM, maligned_store_addr_MEM  in  1 each  exception flags
- dmem_axi_bresp_MEM, dmem_axi_rresp_MEM  in  2 each  data responses; MEM stage drives 0 when unused
- retire_valid  out  1  one-cycle pulse per retired instruction
- retire_PC  out  32  PC of the retired instruction
- trap_valid  out  1  trap request to the CSR unit
- trap_ready  in  1  CSR unit accepts the trap
- trap_cause  out  4  RISC-V mcause code
- trap_epc  out  32  faulting PC
- trap_tval  out  32  mtval value
- flush  out  1  one-cycle pipeline flush after a trap
- cycle_cnt, instret_cnt  out  64 each  performance counters

Function
REQ-002 The FSM SHALL have three states: RUN, TRAP_REQ and FLUSH.
REQ-003 ready_out SHALL be 1 only in RUN; a transfer occurs when valid_in and ready_out are both 1.
REQ-004 On a transfer with no exception flag set, the block SHALL assert retire_valid=1 and retire_PC=PC_MEM in the next cycle (latency 1), and remain in RUN.
REQ-005 An exception SHALL be detected when any flag is set, imem_axi_rresp_MEM!=0, dmem_axi_rresp_MEM!=0, or dmem_axi_bresp_MEM!=0.
REQ-006 If more than one cause is present, the highest-priority cause SHALL be taken. Priority order, with cause code and tval:
- fetch fault: cause 1, tval = PC_MEM
- illegal instruction: cause 2, tval = IR_MEM
- misaligned instruction address: cause 0, tval = addr_MEM
- misaligned load: cause 4, tval = addr_MEM
- misaligned store: cause 6, tval = addr_MEM
- load access fault (rresp): cause 5, tval = addr_MEM
- store access fault (bresp): cause 7, tval = addr_MEM
REQ-007 On a transfer with an exception, the block SHALL register trap_cause, trap_epc=PC_MEM and trap_tval, SHALL NOT pulse retire_valid, and SHALL go to TRAP_REQ.
REQ-008 In TRAP_REQ, trap_valid SHALL be 1 and the trap_* outputs SHALL be held stable until trap_ready=1; the cycle trap_valid and trap_ready are both 1 SHALL be the handshake, after which the FSM goes to FLUSH.
REQ-009 In FLUSH, flush SHALL be 1 for exactly one cycle, then the FSM returns to RUN; valid_in is ignored while in TRAP_REQ and FLUSH.
REQ-010 trap_valid SHALL be 0 outside TRAP_REQ, and flush SHALL be 0 outside FLUSH.

Reset
REQ-011 Reset SHALL take priority over every other event, including reset during TRAP_REQ or FLUSH.
REQ-012 On reset the block SHALL set: state=RUN, retire_valid=0, retire_PC=0, trap_valid=0, trap_cause=0, trap_epc=0, trap_tval=0, flush=0, cycle_cnt=0, instret_cnt=0. ready_out is 1 in the first cycle after reset.

Configuration
REQ-013 With macro WB_PERF_COUNTERS_EN defined:
- cycle_cnt SHALL increment every non-reset cycle.
- instret_cnt SHALL increment in the cycle retire_valid is asserted.
- Both counters SHALL be 64 bit and wrap from 2^64-1 to 0.
REQ-014 Without WB_PERF_COUNTERS_EN, cycle_cnt and instret_cnt SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-015 Retire: after reset, three back-to-back clean transfers with PC 0x0, 0x4, 0x8 -> retire_valid high for 3 consecutive cycles with those PCs; instret_cnt=3.
REQ-016 Priority: transfer with illegal_inst_MEM=1, maligned_load_addr_MEM=1, IR_MEM=0xFFFFFFFF -> trap_cause=2, trap_tval=0xFFFFFFFF, no retire.
REQ-017 Stall: load fault (dmem_axi_rresp_MEM=2, addr_MEM=0x1000) with trap_ready held 0 for 5 cycles -> trap_valid and trap_* stable for 5 cycles, ready_out=0; trap_ready=1 -> flush pulses exactly 1 cycle, then ready_out=1.
REQ-018 Reset mid-trap: reset asserted in TRAP_REQ -> next cycle trap_valid=0, flush=0, ready_out=1, counters=0.
REQ-019 Wrap (WB_PERF_COUNTERS_EN defined): force cycle_cnt to 0xFFFFFFFFFFFFFFFF -> next cycle 0; with the macro undefined, both counters read 0 throughout REQ-015.

Source files
------------

// File: rtl/wb_stage_if.sv
// Bundle of signals between the MEM stage, wb_stage and the CSR unit.
// The master side is the MEM stage / CSR unit; wb_stage uses the slave modport.
interface wb_stage_if;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] PC_MEM;
    logic [31:0] IR_MEM;
    logic [31:0] addr_MEM;
    logic [1:0]  imem_axi_rresp_MEM;
    logic        illegal_inst_MEM;
    logic        maligned_inst_addr_MEM;
    logic        maligned_load_addr_MEM;
    logic        maligned_store_addr_MEM;
    logic [1:0]  dmem_axi_bresp_MEM;
    logic [1:0]  dmem_axi_rresp_MEM;
    logic        retire_valid;
    logic [31:0] retire_PC;
    logic        trap_valid;
    logic        trap_ready;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        flush;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    modport master (
        output valid_in, PC_MEM, IR_MEM, addr_MEM, imem_axi_rresp_MEM,
               illegal_inst_MEM, maligned_inst_addr_MEM, maligned_load_addr_MEM,
               maligned_store_addr_MEM, dmem_axi_bresp_MEM, dmem_axi_rresp_MEM,
               trap_ready,
        input  ready_out, retire_valid, retire_PC, trap_valid, trap_cause,
               trap_epc, trap_tval, flush, cycle_cnt, instret_cnt
    );

    modport slave (
        input  valid_in, PC_MEM, IR_MEM, addr_MEM, imem_axi_rresp_MEM,
               illegal_inst_MEM, maligned_inst_addr_MEM, maligned_load_addr_MEM,
               maligned_store_addr_MEM, dmem_axi_bresp_MEM, dmem_axi_rresp_MEM,
               trap_ready,
        output ready_out, retire_valid, retire_PC, trap_valid, trap_cause,
               trap_epc, trap_tval, flush, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: retires clean MEM results, or raises a prioritised trap to the CSR unit
// and flushes the pipeline. Optional performance counters are enabled by WB_PERF_COUNTERS_EN.
module wb_stage (
    input  logic      clk,
    input  logic      reset,
    wb_stage_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        TRAP_REQ = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic        accept;
    logic        fetch_fault;
    logic        load_fault;
    logic        store_fault;
    logic        exc;
    logic [3:0]  cause_d;
    logic [31:0] tval_d;

    logic        retire_valid_q;
    logic [31:0] retire_pc_q;
    logic [3:0]  trap_cause_q;
    logic [31:0] trap_epc_q;
    logic [31:0] trap_tval_q;

    logic        ready_out;
    logic        trap_valid;
    logic        flush;

    assign fetch_fault = bus.imem_axi_rresp_MEM != 2'b00;
    assign load_fault  = bus.dmem_axi_rresp_MEM != 2'b00;
    assign store_fault = bus.dmem_axi_bresp_MEM != 2'b00;

    assign exc = fetch_fault | bus.illegal_inst_MEM | bus.maligned_inst_addr_MEM |
                 bus.maligned_load_addr_MEM | bus.maligned_store_addr_MEM |
                 load_fault | store_fault;

    assign accept = bus.valid_in && (state_q == RUN);

    // Highest-priority cause wins; the if-chain order is the architectural priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cause_d = 4'd0;
        tval_d  = 32'd0;
        if (fetch_fault) begin
            cause_d = 4'd1;
            tval_d  = bus.PC_MEM;
        end else if (bus.illegal_inst_MEM) begin
            cause_d = 4'd2;
            tval_d  = bus.IR_MEM;
        end else if (bus.maligned_inst_addr_MEM) begin
            cause_d = 4'd0;
            tval_d  = bus.addr_MEM;
        end else if (bus.maligned_load_addr_MEM) begin
            cause_d = 4'd4;
            tval_d  = bus.addr_MEM;
        end else if (bus.maligned_store_addr_MEM) begin
            cause_d = 4'd6;
            tval_d  = bus.addr_MEM;
        end else if (load_fault) begin
            cause_d = 4'd5;
            tval_d  = bus.addr_MEM;
        end else if (store_fault) begin
            cause_d = 4'd7;
            tval_d  = bus.addr_MEM;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (accept && exc)  state_d = TRAP_REQ;
            TRAP_REQ: if (bus.trap_ready) state_d = FLUSH;
            FLUSH:                        state_d = RUN;
            default:                      state_d = RUN;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ready_out  = 1'b0;
        trap_valid = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            RUN:      ready_out  = 1'b1;
            TRAP_REQ: trap_valid = 1'b1;
            FLUSH:    flush      = 1'b1;
            default:  ready_out  = 1'b0;
        endcase
    end

    // Trap fields load only on an accepted faulting transfer, so they hold through TRAP_REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_valid_q <= 1'b0;
            retire_pc_q    <= 32'd0;
            trap_cause_q   <= 4'd0;
            trap_epc_q     <= 32'd0;
            trap_tval_q    <= 32'd0;
        end else begin
            retire_valid_q <= accept && !exc;
            if (accept && !exc) begin
                retire_pc_q <= bus.PC_MEM;
            end
            if (accept && exc) begin
                trap_cause_q <= cause_d;
                trap_epc_q   <= bus.PC_MEM;
                trap_tval_q  <= tval_d;
            end
        end
    end

`ifdef WB_PERF_COUNTERS_EN
    logic [63:0] cycle_cnt_q;
    logic [63:0] instret_cnt_q;

    // Both counters wrap naturally at 2^64.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= 64'd0;
            instret_cnt_q <= 64'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (retire_valid_q) begin
                instret_cnt_q <= instret_cnt_q + 64'd1;
            end
        end
    end

    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.instret_cnt = instret_cnt_q;
`else
    assign bus.cycle_cnt   = 64'd0;
    assign bus.instret_cnt = 64'd0;
`endif

    assign bus.ready_out    = ready_out;
    assign bus.trap_valid   = trap_valid;
    assign bus.flush        = flush;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_PC    = retire_pc_q;
    assign bus.trap_cause   = trap_cause_q;
    assign bus.trap_epc     = trap_epc_q;
    assign bus.trap_tval    = trap_tval_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver pushes expected retires/traps from a priority-list
// model, and a negedge monitor pops and compares whenever the DUT presents a retire or trap.
module tb_wb_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] addr;
        logic [1:0]  irresp;
        logic        illegal;
        logic        mis_inst;
        logic        mis_load;
        logic        mis_store;
        logic [1:0]  drresp;
        logic [1:0]  dbresp;
    } txn_t;

    typedef struct {
        logic [3:0]  cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } trap_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if bus();

    wb_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_retire_q[$];
    trap_t       exp_trap_q[$];
    logic [63:0] exp_cycle   = 64'd0;
    logic [63:0] exp_instret = 64'd0;
    logic        trap_seen   = 1'b0;
    trap_t       trap_held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collect every present cause in architectural priority order, take the first.
    function automatic void model(input txn_t t, output logic is_exc, output trap_t tr);
        trap_t cands[$];
        trap_t c;
        c.epc = t.pc;
        if (t.irresp != 0)  begin c.cause = 4'd1; c.tval = t.pc;   cands.push_back(c); end
        if (t.illegal)      begin c.cause = 4'd2; c.tval = t.ir;   cands.push_back(c); end
        if (t.mis_inst)     begin c.cause = 4'd0; c.tval = t.addr; cands.push_back(c); end
        if (t.mis_load)     begin c.cause = 4'd4; c.tval = t.addr; cands.push_back(c); end
        if (t.mis_store)    begin c.cause = 4'd6; c.tval = t.addr; cands.push_back(c); end
        if (t.drresp != 0)  begin c.cause = 4'd5; c.tval = t.addr; cands.push_back(c); end
        if (t.dbresp != 0)  begin c.cause = 4'd7; c.tval = t.addr; cands.push_back(c); end
        is_exc = cands.size() > 0;
        tr     = is_exc ? cands[0] : c;
    endfunction

    function automatic txn_t clean(input logic [31:0] pc);
        txn_t t;
        t.pc = pc; t.ir = 32'h0000_0013; t.addr = 32'd0; t.irresp = 2'd0;
        t.illegal = 0; t.mis_inst = 0; t.mis_load = 0; t.mis_store = 0;
        t.drresp = 2'd0; t.dbresp = 2'd0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t  t;
        logic  e;
        trap_t tr;
        t = clean($urandom & 32'hFFFF_FFFC);
        t.ir   = $urandom;
        t.addr = $urandom;
        if ($urandom_range(0, 9) < 4) begin
            t.irresp    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            t.illegal   = ($urandom_range(0, 4) == 0);
            t.mis_inst  = ($urandom_range(0, 4) == 0);
            t.mis_load  = ($urandom_range(0, 4) == 0);
            t.mis_store = ($urandom_range(0, 4) == 0);
            t.drresp    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            t.dbresp    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            model(t, e, tr);
            if (!e) t.dbresp = 2'd2;
        end
        return t;
    endfunction

    task automatic drive(input txn_t t);
        bus.PC_MEM                  = t.pc;
        bus.IR_MEM                  = t.ir;
        bus.addr_MEM                = t.addr;
        bus.imem_axi_rresp_MEM      = t.irresp;
        bus.illegal_inst_MEM        = t.illegal;
        bus.maligned_inst_addr_MEM  = t.mis_inst;
        bus.maligned_load_addr_MEM  = t.mis_load;
        bus.maligned_store_addr_MEM = t.mis_store;
        bus.dmem_axi_rresp_MEM      = t.drresp;
        bus.dmem_axi_bresp_MEM      = t.dbresp;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the transfer edge.
    task automatic issue(input txn_t t);
        int    budget;
        logic  is_exc;
        trap_t tr;
        budget = 0;
        drive(t);
        bus.valid_in = 1'b1;
        while (!bus.ready_out && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.ready_out) begin
            check("issue_ready_timeout", 64'(bus.ready_out), 64'd1);
            bus.valid_in = 1'b0;
            return;
        end
        model(t, is_exc, tr);
        if (is_exc) exp_trap_q.push_back(tr);
        else        exp_retire_q.push_back(t.pc);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        if (is_exc) begin
            check("trap_latency", 64'(bus.trap_valid), 64'd1);
            check("no_retire_on_trap", 64'(bus.retire_valid), 64'd0);
        end else begin
            check("retire_latency", 64'(bus.retire_valid), 64'd1);
            check("retire_pc_latency", 64'(bus.retire_PC), 64'(t.pc));
        end
    endtask

    // Holds trap_ready low for 'delay' cycles while offering junk on valid_in, then handshakes.
    task automatic service_trap(input int delay);
        drive(rand_txn());
        bus.valid_in   = 1'b1;
        bus.trap_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            check("stall_trap_valid", 64'(bus.trap_valid), 64'd1);
            check("stall_ready_low", 64'(bus.ready_out), 64'd0);
            @(posedge clk); #1;
        end
        check("pre_hs_trap_valid", 64'(bus.trap_valid), 64'd1);
        bus.trap_ready = 1'b1;
        @(posedge clk); #1;
        bus.trap_ready = 1'b0;
        check("flush_high", 64'(bus.flush), 64'd1);
        check("flush_trap_valid_low", 64'(bus.trap_valid), 64'd0);
        check("flush_ready_low", 64'(bus.ready_out), 64'd0);
        @(posedge clk); #1;
        check("flush_one_cycle", 64'(bus.flush), 64'd0);
        check("ready_after_flush", 64'(bus.ready_out), 64'd1);
        bus.valid_in = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) exp_cycle = 64'd0;
        else       exp_cycle = exp_cycle + 64'd1;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            trap_seen   = 1'b0;
            exp_instret = 64'd0;
        end else begin
            check("state_onehot", 64'($countones({bus.ready_out, bus.trap_valid, bus.flush})), 64'd1);
`ifdef WB_PERF_COUNTERS_EN
            check("cycle_cnt", bus.cycle_cnt, exp_cycle);
            check("instret_cnt", bus.instret_cnt, exp_instret);
`else
            check("cycle_cnt_zero", bus.cycle_cnt, 64'd0);
            check("instret_cnt_zero", bus.instret_cnt, 64'd0);
`endif
            if (bus.retire_valid) begin
                if (exp_retire_q.size() == 0) begin
                    check("retire_unexpected", 64'd1, 64'd0);
                end else begin
                    check("retire_pc", 64'(bus.retire_PC), 64'(exp_retire_q.pop_front()));
                    exp_instret = exp_instret + 64'd1;
                end
            end
            if (bus.trap_valid) begin
                if (!trap_seen) begin
                    if (exp_trap_q.size() == 0) begin
                        check("trap_unexpected", 64'd1, 64'd0);
                        trap_held.cause = bus.trap_cause;
                        trap_held.epc   = bus.trap_epc;
                        trap_held.tval  = bus.trap_tval;
                    end else begin
                        trap_held = exp_trap_q.pop_front();
                        check("trap_cause", 64'(bus.trap_cause), 64'(trap_held.cause));
                        check("trap_epc", 64'(bus.trap_epc), 64'(trap_held.epc));
                        check("trap_tval", 64'(bus.trap_tval), 64'(trap_held.tval));
                    end
                    trap_seen = 1'b1;
                end else begin
                    check("trap_cause_stable", 64'(bus.trap_cause), 64'(trap_held.cause));
                    check("trap_epc_stable", 64'(bus.trap_epc), 64'(trap_held.epc));
                    check("trap_tval_stable", 64'(bus.trap_tval), 64'(trap_held.tval));
                end
            end else begin
                trap_seen = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bus.valid_in   = 1'b0;
        bus.trap_ready = 1'b0;
        drive(clean(32'd0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_retire_valid", 64'(bus.retire_valid), 64'd0);
        check("rst_retire_pc", 64'(bus.retire_PC), 64'd0);
        check("rst_trap_valid", 64'(bus.trap_valid), 64'd0);
        check("rst_trap_cause", 64'(bus.trap_cause), 64'd0);
        check("rst_trap_epc", 64'(bus.trap_epc), 64'd0);
        check("rst_trap_tval", 64'(bus.trap_tval), 64'd0);
        check("rst_flush", 64'(bus.flush), 64'd0);
        check("rst_cycle_cnt", bus.cycle_cnt, 64'd0);
        check("rst_instret_cnt", bus.instret_cnt, 64'd0);
        check("rst_ready_out", 64'(bus.ready_out), 64'd1);
        reset = 1'b0;

        // Three back-to-back clean retires
        issue(clean(32'h0));
        issue(clean(32'h4));
        issue(clean(32'h8));
        @(posedge clk); #1;
        check("retire_gap_after_burst", 64'(bus.retire_valid), 64'd0);
`ifdef WB_PERF_COUNTERS_EN
        check("instret_after_burst", bus.instret_cnt, 64'd3);
`else
        check("instret_after_burst", bus.instret_cnt, 64'd0);
`endif

        // Illegal instruction beats misaligned load
        t = clean(32'h100);
        t.ir       = 32'hFFFF_FFFF;
        t.illegal  = 1'b1;
        t.mis_load = 1'b1;
        issue(t);
        check("prio_cause", 64'(bus.trap_cause), 64'd2);
        check("prio_tval", 64'(bus.trap_tval), 64'hFFFF_FFFF);
        service_trap(1);

        // Load access fault with a 5-cycle CSR stall
        t = clean(32'h200);
        t.addr   = 32'h1000;
        t.drresp = 2'd2;
        issue(t);
        service_trap(5);

        // Reset while in TRAP_REQ
        t = clean(32'h300);
        t.irresp = 2'd1;
        issue(t);
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midtrap_trap_valid", 64'(bus.trap_valid), 64'd0);
        check("midtrap_flush", 64'(bus.flush), 64'd0);
        check("midtrap_ready", 64'(bus.ready_out), 64'd1);
        check("midtrap_cycle_cnt", bus.cycle_cnt, 64'd0);
        check("midtrap_instret_cnt", bus.instret_cnt, 64'd0);
        check("midtrap_trap_cause", 64'(bus.trap_cause), 64'd0);
        bus.valid_in = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef WB_PERF_COUNTERS_EN
        // Cycle counter wrap
        force dut.cycle_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        @(posedge clk); #1;
        check("cycle_wrap", bus.cycle_cnt, 64'd0);
`endif

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            logic  e;
            trap_t tr;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            t = rand_txn();
            issue(t);
            model(t, e, tr);
            if (e) service_trap($urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("retire_q_drained", 64'(exp_retire_q.size()), 64'd0);
        check("trap_q_drained", 64'(exp_trap_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
